// File: rtl/rom_region_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_region_reader
// Brief    : Reads a byte range of a ROM load region back out of SDRAM
//            (64-bit words, optional reorder_64 lane permutation) or out of a
//            BRAM chip-select region (bytes). Emits an in-order byte stream
//            with a valid/ready handshake.
// Options  : ROM_READER_PREFETCH_EN - two-entry word buffer; the next SDRAM
//            word is requested while the current one is still being emitted.
// Revision : 1.0 - initial release
// ============================================================================
module rom_region_reader #(
  parameter int BRAM_LATENCY = 1,
  parameter int LEN_W        = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic [30:0]      req_region,
  input  logic [24:0]      req_offset,
  input  logic [LEN_W-1:0] req_len,
  output logic             busy,
  output logic             done,
  output logic [24:0]      sdr_addr,
  output logic             sdr_req,
  input  logic             sdr_ack,
  input  logic [63:0]      sdr_data,
  output logic [4:0]       bram_cs,
  output logic [24:0]      bram_addr,
  output logic             bram_rd,
  input  logic [7:0]       bram_data,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_SDR_REQ   = 3'd1,
    S_SDR_EMIT  = 3'd2,
    S_BRAM_RD   = 3'd3,
    S_BRAM_WAIT = 3'd4,
    S_BRAM_EMIT = 3'd5,
    S_DONE      = 3'd6
  } state_t;

  localparam logic [1:0]       c_bram_lat = 2'(BRAM_LATENCY);
  localparam logic [LEN_W-1:0] c_len_one  = LEN_W'(1);

  // Loader stores source byte b of a word in lane {b[1:0],b[2]} when reorder_64.
  function automatic logic [7:0] pick_lane(input logic [63:0] word,
                                           input logic [2:0]  pos,
                                           input logic        reo);
    logic [2:0] lane;
    lane = reo ? {pos[1:0], pos[2]} : pos;
    return word[{lane, 3'b000} +: 8];
  endfunction

  // Control state
  state_t           state_q, state_d;
  logic [24:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             reorder_q, reorder_d;
  logic [4:0]       cs_q, cs_d;
  logic [63:0]      word_q, word_d;
  logic [1:0]       lat_q, lat_d;
`ifdef ROM_READER_PREFETCH_EN
  logic [63:0]      nxt_word_q, nxt_word_d;
  logic             nxt_vld_q, nxt_vld_d;
  logic             w_pf_issue;
`endif

  // Registered outputs
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [24:0]      sdr_addr_q, sdr_addr_d;
  logic             sdr_req_q, sdr_req_d;
  logic [4:0]       bram_cs_q, bram_cs_d;
  logic [24:0]      bram_addr_q, bram_addr_d;
  logic             bram_rd_q, bram_rd_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q, out_last_d;

  logic [24:0]      w_eff_addr;
  logic             w_hs;
  logic             w_cross;
  logic [3:0]       w_word_left;

  assign w_eff_addr  = req_region[30:6] + req_offset;
  assign w_hs        = out_valid_q & out_ready;
  // Handshake on byte 7 of a word with more bytes still to come.
  assign w_cross     = w_hs && (addr_q[2:0] == 3'd7) && (len_q != c_len_one);
  assign w_word_left = 4'd8 - {1'b0, addr_q[2:0]};

`ifdef ROM_READER_PREFETCH_EN
  // Fetch the following word only when the transfer actually reaches into it.
  assign w_pf_issue = (state_q == S_SDR_EMIT) && !sdr_req_q && !nxt_vld_q &&
                      !w_cross && (len_q > LEN_W'(w_word_left));
`endif

  // Next-state and next-output computation; outputs decode from next state.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    reorder_d   = reorder_q;
    cs_d        = cs_q;
    word_d      = word_q;
    lat_d       = lat_q;
`ifdef ROM_READER_PREFETCH_EN
    nxt_word_d  = nxt_word_q;
    nxt_vld_d   = nxt_vld_q;
`endif
    sdr_addr_d  = sdr_addr_q;
    bram_addr_d = bram_addr_q;

    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d    = w_eff_addr;
          len_d     = req_len;
          reorder_d = req_region[5];
          cs_d      = req_region[4:0];
`ifdef ROM_READER_PREFETCH_EN
          nxt_vld_d = 1'b0;
`endif
          if (req_len == '0) begin
            state_d = S_DONE;
          end else if (req_region[4:0] != 5'd0) begin
            state_d = S_BRAM_RD;
          end else begin
            state_d = S_SDR_REQ;
          end
        end
      end

      S_SDR_REQ: begin
        if (sdr_req_q && sdr_ack) begin
          word_d  = sdr_data;
          state_d = S_SDR_EMIT;
        end
      end

      S_SDR_EMIT: begin
`ifdef ROM_READER_PREFETCH_EN
        // A prefetched word parks in the second entry unless it is needed now.
        if (sdr_req_q && sdr_ack && !w_cross) begin
          nxt_word_d = sdr_data;
          nxt_vld_d  = 1'b1;
        end
`endif
        if (w_hs) begin
          addr_d = addr_q + 25'd1;
          len_d  = len_q - c_len_one;
          if (len_q == c_len_one) begin
            state_d = S_DONE;
          end else if (w_cross) begin
`ifdef ROM_READER_PREFETCH_EN
            if (nxt_vld_q) begin
              word_d    = nxt_word_q;
              nxt_vld_d = 1'b0;
            end else if (sdr_req_q && sdr_ack) begin
              word_d = sdr_data;
            end else begin
              state_d = S_SDR_REQ;
            end
`else
            state_d = S_SDR_REQ;
`endif
          end
        end
      end

      S_BRAM_RD: begin
        lat_d   = 2'd1;
        state_d = S_BRAM_WAIT;
      end

      S_BRAM_WAIT: begin
        if (lat_q == c_bram_lat) begin
          word_d  = {56'd0, bram_data};
          state_d = S_BRAM_EMIT;
        end else begin
          lat_d = lat_q + 2'd1;
        end
      end

      S_BRAM_EMIT: begin
        if (w_hs) begin
          addr_d  = addr_q + 25'd1;
          len_d   = len_q - c_len_one;
          state_d = (len_q == c_len_one) ? S_DONE : S_BRAM_RD;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);

    // SDRAM request: held from entry into SDR_REQ until the ack.
    sdr_req_d = (state_d == S_SDR_REQ);
    if ((state_d == S_SDR_REQ) && !sdr_req_q) begin
      sdr_addr_d = {addr_d[24:3], 3'b000};
    end
`ifdef ROM_READER_PREFETCH_EN
    if (w_pf_issue) begin
      sdr_addr_d = {addr_q[24:3] + 22'd1, 3'b000};
    end
    sdr_req_d = sdr_req_d | w_pf_issue |
                ((state_q == S_SDR_EMIT) && (state_d == S_SDR_EMIT) &&
                 sdr_req_q && !sdr_ack);
`endif

    // BRAM strobe lasts the single BRAM_RD cycle; cs held for the whole access.
    bram_rd_d = (state_d == S_BRAM_RD);
    if (state_d == S_BRAM_RD) begin
      bram_addr_d = addr_d;
    end
    bram_cs_d = ((state_d == S_BRAM_RD) || (state_d == S_BRAM_WAIT) ||
                 (state_d == S_BRAM_EMIT)) ? cs_d : 5'd0;

    // Stream byte; without a handshake every input to this is unchanged.
    out_valid_d = (state_d == S_SDR_EMIT) || (state_d == S_BRAM_EMIT);
    if (state_d == S_SDR_EMIT) begin
      out_data_d = pick_lane(word_d, addr_d[2:0], reorder_d);
    end else if (state_d == S_BRAM_EMIT) begin
      out_data_d = word_d[7:0];
    end else begin
      out_data_d = 8'd0;
    end
    out_last_d = out_valid_d && (len_d == c_len_one);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      reorder_q   <= 1'b0;
      cs_q        <= '0;
      word_q      <= '0;
      lat_q       <= '0;
`ifdef ROM_READER_PREFETCH_EN
      nxt_word_q  <= '0;
      nxt_vld_q   <= 1'b0;
`endif
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sdr_addr_q  <= '0;
      sdr_req_q   <= 1'b0;
      bram_cs_q   <= '0;
      bram_addr_q <= '0;
      bram_rd_q   <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      reorder_q   <= reorder_d;
      cs_q        <= cs_d;
      word_q      <= word_d;
      lat_q       <= lat_d;
`ifdef ROM_READER_PREFETCH_EN
      nxt_word_q  <= nxt_word_d;
      nxt_vld_q   <= nxt_vld_d;
`endif
      busy_q      <= busy_d;
      done_q      <= done_d;
      sdr_addr_q  <= sdr_addr_d;
      sdr_req_q   <= sdr_req_d;
      bram_cs_q   <= bram_cs_d;
      bram_addr_q <= bram_addr_d;
      bram_rd_q   <= bram_rd_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign sdr_addr  = sdr_addr_q;
  assign sdr_req   = sdr_req_q;
  assign bram_cs   = bram_cs_q;
  assign bram_addr = bram_addr_q;
  assign bram_rd   = bram_rd_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_region_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_region_reader
// Brief    : Self-checking bench for rom_region_reader with SDRAM/BRAM
//            responders and a byte-level expected-stream model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_region_reader;

  localparam int LAT = 2;
  localparam int LW  = 25;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req = 1'b0;
  logic [30:0]   req_region = '0;
  logic [24:0]   req_offset = '0;
  logic [LW-1:0] req_len = '0;
  logic          busy, done, sdr_req, bram_rd, out_valid, out_last;
  logic [24:0]   sdr_addr, bram_addr;
  logic [4:0]    bram_cs;
  logic [7:0]    out_data;
  logic          sdr_ack = 1'b0;
  logic [63:0]   sdr_data = '0;
  logic [7:0]    bram_data = '0;
  logic          out_ready = 1'b1;

  always #5 clk = ~clk;

  rom_region_reader #(.BRAM_LATENCY(LAT), .LEN_W(LW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_region(req_region),
    .req_offset(req_offset), .req_len(req_len), .busy(busy), .done(done),
    .sdr_addr(sdr_addr), .sdr_req(sdr_req), .sdr_ack(sdr_ack),
    .sdr_data(sdr_data), .bram_cs(bram_cs), .bram_addr(bram_addr),
    .bram_rd(bram_rd), .bram_data(bram_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Backing memories: logical source byte at address A, and BRAM contents.
  logic [7:0] sdr_mem [256];
  logic [7:0] bram_mem[256];

  function automatic logic [7:0] src_byte(input logic [24:0] a);
    return sdr_mem[a[7:0]] ^ a[15:8];
  endfunction

  // Word as the loader laid it out in SDRAM.
  function automatic logic [63:0] model_word(input logic [24:0] wa, input logic reo);
    int lane_of[8] = '{0, 2, 4, 6, 1, 3, 5, 7};
    logic [63:0] w;
    int lane;
    w = '0;
    for (int b = 0; b < 8; b++) begin
      lane = reo ? lane_of[b] : b;
      w[8*lane +: 8] = src_byte({wa[24:3], 3'(b)});
    end
    return w;
  endfunction

  // Expectations and logs
  logic [7:0]  exp_data_q[$];
  bit          exp_last_q[$];
  logic [24:0] exp_sdr_q[$];
  logic [24:0] exp_bram_q[$];
  logic [4:0]  exp_cs = '0;
  logic [7:0]  cap_q[$];
  bit          cap_last_q[$];
  logic [24:0] sdr_log[$];
  logic [24:0] bram_log[$];
  int          n_done = 0;
  int          cyc = 0;
  int          first_hs = -1;
  int          last_hs = -1;

  // Bench controls
  int   rdy_mode = 0;
  logic cur_reorder = 1'b0;
  bit   sdr_hold = 1'b0;
  bit   force_ack = 1'b0;

  // Monitor-local state
  bit          stall_prev = 1'b0;
  logic [7:0]  prev_data = '0;
  logic        prev_last = 1'b0;
  bit          req_prev = 1'b0;
  int          sdr_wait = 0;
  int          sdr_lat = 2;
  int          bcnt = -1;
  logic [24:0] bram_a = '0;

  // Mid-cycle: drive ready, check outputs, then drive memory responses.
  always @(negedge clk) begin
    cyc++;
    out_ready = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;

    if (reset) begin
      stall_prev = 1'b0;
      req_prev   = 1'b0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 64'(out_valid), 64'd1);
        check("stall_data", 64'(out_data), 64'(prev_data));
        check("stall_last", 64'(out_last), 64'(prev_last));
      end
      if (out_valid && out_ready) begin
        cap_q.push_back(out_data);
        cap_last_q.push_back(out_last);
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
        if (exp_data_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_byte: got 0x%0h expected no byte", out_data);
        end else begin
          check("byte", 64'(out_data), 64'(exp_data_q.pop_front()));
          check("last", 64'(out_last), 64'(exp_last_q.pop_front()));
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;

      if (sdr_req && !req_prev) begin
        sdr_log.push_back(sdr_addr);
        if (exp_sdr_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_sdr_req: got addr 0x%0h expected no request", sdr_addr);
        end else begin
          check("sdr_addr", 64'(sdr_addr), 64'(exp_sdr_q.pop_front()));
        end
      end
      req_prev = sdr_req;

      if (bram_rd) begin
        bram_log.push_back(bram_addr);
        if (exp_bram_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_bram_rd: got addr 0x%0h expected no read", bram_addr);
        end else begin
          check("bram_addr", 64'(bram_addr), 64'(exp_bram_q.pop_front()));
          check("bram_cs", 64'(bram_cs), 64'(exp_cs));
        end
      end
      if (done) n_done++;
    end

    // SDRAM responder
    if (force_ack) begin
      sdr_ack  = 1'b1;
      sdr_data = {$urandom, $urandom};
    end else if (sdr_req && !sdr_ack && !sdr_hold) begin
      sdr_wait++;
      if (sdr_wait >= sdr_lat) begin
        sdr_ack  = 1'b1;
        sdr_data = model_word(sdr_addr, cur_reorder);
        sdr_wait = 0;
        sdr_lat  = $urandom_range(1, 4);
      end else begin
        sdr_ack = 1'b0;
      end
    end else begin
      sdr_ack = 1'b0;
    end

    // BRAM responder: data valid only LAT cycles after the strobe.
    if (bram_rd) begin
      bcnt   = 0;
      bram_a = bram_addr;
    end else if (bcnt >= 0) begin
      bcnt++;
      if (bcnt > LAT + 4) bcnt = -1;
    end
    bram_data = (bcnt == LAT) ? bram_mem[bram_a[7:0]] : 8'($urandom);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_model();
    exp_data_q.delete(); exp_last_q.delete(); exp_sdr_q.delete(); exp_bram_q.delete();
    cap_q.delete(); cap_last_q.delete(); sdr_log.delete(); bram_log.delete();
    n_done = 0; first_hs = -1; last_hs = -1;
  endtask

  task automatic run_xfer(input logic [24:0] base, input logic reo, input logic [4:0] cs,
                          input logic [24:0] off, input int len, input int rmode, input bit dup);
    logic [24:0] eff, a;
    int nw;
    bit got;
    clear_model();
    eff = base + off;
    cur_reorder = reo;
    exp_cs = cs;
    rdy_mode = rmode;
    for (int i = 0; i < len; i++) begin
      a = eff + 25'(i);
      exp_data_q.push_back((cs != 0) ? bram_mem[a[7:0]] : src_byte(a));
      exp_last_q.push_back(i == len - 1);
      if (cs != 0) exp_bram_q.push_back(a);
    end
    if (len > 0 && cs == 0) begin
      nw = (int'(eff[2:0]) + len + 7) / 8;
      for (int w = 0; w < nw; w++) exp_sdr_q.push_back({eff[24:3], 3'b000} + 25'(8 * w));
    end
    tick();
    req = 1'b1; req_region = {base, reo, cs}; req_offset = off; req_len = LW'(len);
    tick();
    req = 1'b0;
    if (len > 0) check("busy_after_req", 64'(busy), 64'd1);
    if (dup) begin
      tick();
      req = 1'b1; req_region = {25'h0, 1'b0, 5'h1}; req_offset = 25'h0; req_len = LW'(5);
      tick();
      req = 1'b0;
    end
    got = 1'b0;
    for (int c = 0; c < 200 + 20 * len && !got; c++) begin
      tick();
      if (n_done > 0) got = 1'b1;
    end
    if (!got) begin
      n_cmp++; n_err++;
      $display("FAIL done_timeout: got no done expected done within budget (len %0d)", len);
      reset = 1'b1; tick(); tick(); reset = 1'b0;
    end
    repeat (4) tick();
    check("done_count", 64'(n_done), 64'd1);
    check("bytes_left", 64'(exp_data_q.size()), 64'd0);
    check("sdr_reqs_left", 64'(exp_sdr_q.size()), 64'd0);
    check("bram_rds_left", 64'(exp_bram_q.size()), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      sdr_mem[i]  = 8'(i);
      bram_mem[i] = 8'(i);
    end

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_sdr_req", 64'(sdr_req), 64'd0);
    check("rst_bram_rd", 64'(bram_rd), 64'd0);
    check("rst_bram_cs", 64'(bram_cs), 64'd0);
    check("rst_out", 64'({out_valid, out_last, out_data}), 64'd0);

    // Pin the memory model with the known word layouts.
    check("model_plain", model_word(25'h0400000, 1'b0), 64'h0706050403020100);
    check("model_reorder", model_word(25'h0400000, 1'b1), 64'h0703060205010400);

    // Unaligned SDRAM read, with a stray req while busy.
    run_xfer(25'h0400000, 1'b0, 5'd0, 25'd3, 10, 0, 1'b1);
    check("t1_count", 64'(cap_q.size()), 64'd10);
    for (int i = 0; i < cap_q.size() && i < 10; i++) check("t1_lit_byte", 64'(cap_q[i]), 64'(3 + i));
    if (cap_last_q.size() == 10) check("t1_last_on_0c", 64'(cap_last_q[9]), 64'd1);
    check("t1_sdr_reqs", 64'(sdr_log.size()), 64'd2);
    if (sdr_log.size() == 2) begin
      check("t1_addr0", 64'(sdr_log[0]), 64'h0400000);
      check("t1_addr1", 64'(sdr_log[1]), 64'h0400008);
    end

    // reorder_64 word
    run_xfer(25'h0400000, 1'b1, 5'd0, 25'd0, 8, 0, 1'b0);
    check("t2_count", 64'(cap_q.size()), 64'd8);
    for (int i = 0; i < cap_q.size() && i < 8; i++) check("t2_lit_byte", 64'(cap_q[i]), 64'(i));

    // BRAM region
    bram_mem[8'h10] = 8'hAA; bram_mem[8'h11] = 8'hBB; bram_mem[8'h12] = 8'hCC;
    run_xfer(25'h0, 1'b1, 5'b00010, 25'h10, 3, 0, 1'b0);
    check("t3_count", 64'(cap_q.size()), 64'd3);
    if (cap_q.size() == 3) check("t3_lit_bytes", 64'({cap_q[0], cap_q[1], cap_q[2]}), 64'hAABBCC);
    check("t3_bram_rds", 64'(bram_log.size()), 64'd3);
    if (bram_log.size() == 3) check("t3_rd_addr2", 64'(bram_log[2]), 64'h12);
    check("t3_no_sdr", 64'(sdr_log.size()), 64'd0);

    // Zero length: done one cycle after req, nothing else.
    clear_model();
    rdy_mode = 0;
    req = 1'b1; req_region = {25'h0400000, 1'b0, 5'd0}; req_offset = 25'd0; req_len = '0;
    tick();
    req = 1'b0;
    check("len0_done", 64'(done), 64'd1);
    check("len0_busy", 64'(busy), 64'd0);
    tick();
    check("len0_done_once", 64'(done), 64'd0);
    repeat (3) tick();
    check("len0_no_bytes", 64'(cap_q.size()), 64'd0);

    // Random back-pressure on a 20-byte reordered read.
    run_xfer(25'h0123450, 1'b1, 5'd0, 25'd5, 20, 1, 1'b0);
    check("t5_count", 64'(cap_q.size()), 64'd20);

    // Aligned read, ready held high.
    run_xfer(25'h0000100, 1'b0, 5'd0, 25'd0, 24, 0, 1'b0);
`ifdef ROM_READER_PREFETCH_EN
    check("no_bubble", 64'(last_hs - first_hs), 64'd23);
`endif

    // Reset while sdr_req pending, followed by a late ack.
    clear_model();
    sdr_hold = 1'b1;
    exp_sdr_q.push_back(25'h0000200);
    req = 1'b1; req_region = {25'h0000200, 1'b0, 5'd0}; req_offset = 25'd0; req_len = LW'(16);
    tick();
    req = 1'b0;
    for (int c = 0; c < 20 && !sdr_req; c++) tick();
    check("rst_mid_req_seen", 64'(sdr_req), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("rst_mid_sdr_req", 64'(sdr_req), 64'd0);
    check("rst_mid_busy", 64'(busy), 64'd0);
    check("rst_mid_out_valid", 64'(out_valid), 64'd0);
    force_ack = 1'b1;
    tick();
    force_ack = 1'b0;
    sdr_hold = 1'b0;
    tick();
    check("late_ack_idle", 64'({busy, sdr_req, out_valid, bram_rd, done}), 64'd0);
    run_xfer(25'h0000300, 1'b0, 5'd0, 25'd2, 4, 0, 1'b0);
    check("post_rst_count", 64'(cap_q.size()), 64'd4);

    // Randomized transfers
    for (int i = 0; i < 256; i++) begin
      sdr_mem[i]  = 8'($urandom);
      bram_mem[i] = 8'($urandom);
    end
    for (int t = 0; t < 40; t++) begin
      logic [24:0] base;
      logic [4:0]  cs;
      base = (t % 8 == 0) ? 25'h1FFFFF0 : 25'($urandom);
      cs   = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      run_xfer(base, 1'($urandom_range(0, 1)), cs, 25'($urandom_range(0, 31)),
               $urandom_range(0, 20), $urandom_range(0, 1), 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rom_region_reader.md
Name: rom_region_reader

Overview:
- Read-side counterpart of the ROM download path.
- Given a load region descriptor (board_pkg::region_t), a byte offset and a length, fetches the bytes back from SDRAM (64-bit words) or from a BRAM chip-select region (bytes).
- Undoes the reorder_64 lane permutation and emits an in-order byte stream with valid/ready handshake.
- Used for the ioctl upload/verify path and debug readback; sits beside the loader on the SDRAM/BRAM arbitration.

Parameters:
- BRAM_LATENCY, 1, cycles from bram_rd assertion to bram_data valid (legal 1..3).
- LEN_W, 25, width of the request length counter.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req  in  1  start pulse, sampled only in IDLE
- req_region  in  31  board_pkg::region_t {base_addr[24:0], reorder_64, bram_cs[4:0]}
- req_offset  in  25  byte offset within region
- req_len  in  LEN_W  byte count
- busy  out  1  high from accepted req until done
- done  out  1  one-cycle pulse at end of transfer
- sdr_addr  out  25  byte address, bits [2:0] forced 0
- sdr_req  out  1  level; held until sdr_ack
- sdr_ack  in  1  one-cycle pulse; sdr_data valid same cycle
- sdr_data  in  64  read word; lane n = bits [8n+7:8n]
- bram_cs  out  5  chip select; 0 when idle
- bram_addr  out  25  byte address
- bram_rd  out  1  one-cycle read strobe
- bram_data  in  8  read byte
- out_data  out  8  stream byte
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_last  out  1  high with the final byte

Behaviour:
- Reset: all outputs 0; state IDLE; pending acks discarded.
- Effective address = base_addr + req_offset, truncated to 25 bits (wraps modulo 2^25).
- IDLE:
  - On req, latch descriptor, address and length; set busy.
  - req_len==0 -> DONE (done pulses next cycle, no bytes out).
  - Otherwise go to BRAM_RD if bram_cs!=0, else SDR_REQ.
  - req while busy is ignored.
- SDR_REQ:
  - Drive sdr_addr={addr[24:3],3'b0} and hold sdr_req=1.
  - On sdr_ack, capture sdr_data into word buffer, drop sdr_req, go to SDR_EMIT.
  - sdr_ack seen in any other state is ignored.
- SDR_EMIT:
  - Byte position b=addr[2:0].
  - Lane = {b[1:0],b[2]} if reorder_64, else b. The loader stores source bytes 0..7 in lanes 0,2,4,6,1,3,5,7.
  - out_valid=1 with the selected lane.
  - Each out_valid&&out_ready advances addr by 1 and decrements len.
  - len reaching 0 -> DONE.
  - addr[2:0] wrapping to 0 -> SDR_REQ.
  - Unaligned start emits only the bytes b..7 of the first word.
- BRAM_RD:
  - Pulse bram_rd with bram_cs=latched cs and bram_addr=addr.
  - Wait BRAM_LATENCY cycles, register bram_data, then go to BRAM_EMIT.
  - BRAM regions ignore reorder_64.
- BRAM_EMIT:
  - out_valid with the registered byte.
  - On handshake, advance addr and len.
  - Go to DONE if len==0, else BRAM_RD.
- DONE: done=1 for one cycle, busy=0, return to IDLE.
- out_last is asserted with the byte for which len==1.
- out_data/out_valid/out_last stay stable while out_valid&&!out_ready.
- Throughput (no prefetch): one SDRAM round trip per 8 bytes; BRAM path is BRAM_LATENCY+2 cycles per byte.
- Reset mid-operation: sdr_req, bram_rd and out_valid drop the cycle after reset is sampled. A late sdr_ack after reset is ignored.

Optional Feature:
- Macro ROM_READER_PREFETCH_EN.
- Defined:
  - Two-entry word buffer.
  - While in SDR_EMIT, if the current word still has bytes and the next word is within len, issue sdr_req for addr+8 immediately.
  - On ack, store the word in the second entry; SDR_EMIT continues straight into it with no bubble when the entry is full.
  - A prefetch never crosses the end of the transfer.
- Undefined: single buffer as above.
- Both builds produce an identical byte stream.

Test Plan:
- SDRAM, reorder_64=0, base 0x0400000, offset 3, len 10, sdr_data words 0x0706050403020100 then 0x0F0E...08 -> bytes 03..0C in order; out_last on 0C; two sdr_req with addr 0x0400000 and 0x0400008; done once.
- reorder_64=1, offset 0, len 8, word lanes 0..7 = 00,04,01,05,02,06,03,07 -> bytes 00..07 in order.
- BRAM cs=5'b00010, offset 0x10, len 3, BRAM_LATENCY=2, data 0xAA,0xBB,0xCC -> three bram_rd at 0x10..0x12; out AA,BB,CC; sdr_req never asserted.
- len=0 -> done one cycle after req; no out_valid, no memory access; second req during busy ignored.
- out_ready toggled randomly on a 20-byte SDRAM read -> out_data stable while stalled; no byte lost or duplicated; with ROM_READER_PREFETCH_EN no bubble between words when out_ready is held high.
- Reset asserted while sdr_req pending, then sdr_ack arrives -> outputs 0, state IDLE; next req of 4 bytes completes correctly.
